adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one 32-bit add unit among N requesters (default: 0 = branch-target calc, 1 = load/store address calc, 2 = PC increment).
- Each request is either "in1 + 4" or "in1 + in2", chosen by the per-request sel bit.
- Round-robin arbitration, one grant per cycle.
- Single registered result slot with valid/ready backpressure toward the consumer.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- WIDTH, 32, operand/result width.
- INC, 4, constant added when sel = 1.
- IDW, 2, width of requester index; must satisfy 2^IDW >= N_REQ.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request strobe.
- req_sel  input  N_REQ  1 = in1 + INC; 0 = in1 + in2.
- req_in1  input  N_REQ*WIDTH  packed operand 1; requester i uses bits [i*WIDTH +: WIDTH].
- req_in2  input  N_REQ*WIDTH  packed operand 2, same packing; ignored when sel = 1.
- req_ready  output  N_REQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i].
- rsp_valid  output  1  result slot holds a valid result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_out  output  WIDTH  sum.
- rsp_id  output  IDW  index of the requester that owns rsp_out.
- busy  output  1  equals rsp_valid (slot occupied).

Behaviour:
- Reset:
  - rsp_valid = 0, rsp_out = 0, rsp_id = 0, busy = 0, round-robin pointer = 0.
  - req_ready is combinational and is therefore 0 while rst = 1.
- Slot state machine, two states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with rsp_ready = 1 (pass-through).
  - FULL -> EMPTY on rsp_ready = 1 with no accept.
  - FULL with rsp_ready = 0: hold; rsp_out and rsp_id stay stable.
- Slot free condition: free = (state == EMPTY) | rsp_ready.
- Grant (combinational):
  - If free, search req_valid starting at index ptr, ascending, wrapping at N_REQ-1 -> 0.
  - The first set bit wins; req_ready is that single bit.
  - If not free, or no request is pending, req_ready = 0.
  - req_ready never depends on req_valid bits of other requesters beyond this priority search.
  - No combinational path from rsp_ready into operand selection except through free.
- Pointer: on accept of requester i, ptr <= (i == N_REQ-1) ? 0 : i+1. Otherwise unchanged.
- Datapath, on accept:
  - rsp_out <= sel ? in1 + INC : in1 + in2.
  - rsp_id <= i.
  - Arithmetic is modulo 2^WIDTH; carry out is discarded (0xFFFF_FFFC + 4 = 0).
- Latency: result is valid exactly 1 cycle after acceptance.
- Throughput: 1 result per cycle while rsp_ready is held high.
- Requester rules:
  - Hold req_valid, sel and operands stable until accepted.
  - Deasserting req_valid before acceptance withdraws the request without side effects.
  - Operands are sampled only in the accept cycle.
- Fairness: a continuously asserted request is granted within N_REQ accepts.
- Reset mid-operation: a pending result is discarded. rsp_valid = 0 the cycle after rst is sampled, and ptr returns to 0.
- Simultaneous drain and accept in FULL: the new result replaces the old one. No bubble, no duplicate.
- rsp_valid must never drop without rsp_ready, except on reset.

Test Plan:
- Single request: reset, then req_valid = 001, sel = 1, in1 = 0x0000_1000 -> req_ready = 001 that cycle; next cycle rsp_valid = 1, rsp_out = 0x0000_1004, rsp_id = 0.
- Two-operand add with wrap: requester 1, sel = 0, in1 = 0xFFFF_FFF0, in2 = 0x20 -> rsp_out = 0x0000_0010, rsp_id = 1.
- Round-robin: all three req_valid held high, rsp_ready = 1 -> grants 001, 010, 100, 001 on consecutive cycles; rsp_id sequence 0, 1, 2, 0 with 1-cycle lag.
- Backpressure: slot FULL, rsp_ready = 0 for 3 cycles with req_valid = 010 -> req_ready = 0, rsp_out/rsp_id unchanged. rsp_ready = 1 -> requester 1 granted that cycle; its result appears the next cycle.
- Pass-through: FULL with rsp_id = 2, rsp_ready = 1 and req_valid = 001 the same cycle -> next cycle rsp_valid = 1, rsp_id = 0, no empty cycle.
- Reset mid-operation: rst = 1 while FULL and requests pending -> next cycle rsp_valid = 0, rsp_out = 0, req_ready = 0. After release with req_valid = 110, grant goes to requester 1 (ptr = 0, first set bit ascending).

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin shared adder with one registered result slot.
// Ports: clk, rst (sync, active-high); req_valid/req_sel/req_in1/req_in2
// per-requester inputs (operands packed, requester i at [i*WIDTH +: WIDTH]);
// req_ready one-hot grant; rsp_valid/rsp_ready/rsp_out/rsp_id result slot
// with backpressure; busy mirrors rsp_valid.
module adder_arbiter #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 32,
    parameter int INC   = 4,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_sel,
    input  logic [N_REQ*WIDTH-1:0] req_in1,
    input  logic [N_REQ*WIDTH-1:0] req_in2,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_out,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam logic [IDW:0]   NR   = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             free;
    logic             accept;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   gidx;
    logic [IDW:0]     scan;
    logic [WIDTH-1:0] op1, op2;

    // A draining consumer frees the slot in the same cycle,
    // which is what allows back-to-back results.
    assign free = (state_q == EMPTY) | rsp_ready;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        grant = '0;
        gidx  = '0;
        scan  = '0;
        if (free && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                scan = {1'b0, ptr_q} + (IDW+1)'(k);
                if (scan >= NR) begin
                    scan = scan - NR;
                end
                if (grant == '0 && req_valid[scan[IDW-1:0]]) begin
                    grant[scan[IDW-1:0]] = 1'b1;
                    gidx = scan[IDW-1:0];
                end
            end
        end
    end

    assign accept    = |grant;
    assign req_ready = grant;

    assign op1 = req_in1[int'(gidx)*WIDTH +: WIDTH];
    assign op2 = req_sel[gidx] ? WIDTH'(INC)
                               : req_in2[int'(gidx)*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = FULL;
            out_d   = op1 + op2;
            id_d    = gidx;
            ptr_d   = (gidx == LAST) ? '0 : gidx + 1'b1;
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign busy      = rsp_valid;
    assign rsp_out   = out_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and randomized checks of adder_arbiter
// against a cycle-level reference model of the slot and rotation.
module tb_adder_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_sel;
    logic [N*W-1:0] req_in1;
    logic [N*W-1:0] req_in2;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_out;
    logic [1:0]     rsp_id;
    logic           busy;

    logic [W-1:0] in1 [N];
    logic [W-1:0] in2 [N];

    bit           m_valid;
    logic [W-1:0] m_out;
    int           m_id;
    int           m_ptr;
    logic [N-1:0] obs_grant;

    int passed = 0;
    int total  = 0;

    adder_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_in1[i*W +: W] = in1[i];
            req_in2[i*W +: W] = in2[i];
        end
    end

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (!rst && (!m_valid || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                if (g == '0 && req_valid[(m_ptr + k) % N]) begin
                    g[(m_ptr + k) % N] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // One clock: check all outputs mid-cycle, then advance the model.
    task automatic cycle();
        logic [N-1:0] eg;
        #3;
        eg = model_grant();
        obs_grant = req_ready;
        chk("req_ready", W'(req_ready), W'(eg));
        chk("rsp_valid", W'(rsp_valid), W'(m_valid));
        chk("busy", W'(busy), W'(m_valid));
        chk("rsp_out", rsp_out, m_out);
        chk("rsp_id", W'(rsp_id), W'(m_id));
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m_out   = '0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (eg != '0) begin
            for (int i = 0; i < N; i++) begin
                if (eg[i]) begin
                    m_valid = 1;
                    m_out   = req_sel[i] ? in1[i] + 32'd4 : in1[i] + in2[i];
                    m_id    = i;
                    m_ptr   = (i + 1) % N;
                end
            end
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    initial begin
        logic [N-1:0] rr_exp [4];
        int rr_id [4];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_id  = '{0, 1, 2, 0};

        m_valid = 0; m_out = '0; m_id = 0; m_ptr = 0;
        rst = 1; req_valid = '0; req_sel = '0; rsp_ready = 0;
        for (int i = 0; i < N; i++) begin
            in1[i] = '0;
            in2[i] = '0;
        end
        cycle();
        cycle();
        chk("reset_valid", W'(rsp_valid), 0);
        chk("reset_out", rsp_out, 0);

        // single increment request
        rst = 0;
        req_valid = 3'b001; req_sel = 3'b001; in1[0] = 32'h0000_1000;
        cycle();
        chk("single_grant", W'(obs_grant), 32'b001);
        req_valid = '0;
        chk("single_out", rsp_out, 32'h0000_1004);
        chk("single_id", W'(rsp_id), 0);
        chk("single_valid", W'(rsp_valid), 1);

        // two-operand add with wrap
        rsp_ready = 1;
        req_valid = 3'b010; req_sel = 3'b000;
        in1[1] = 32'hFFFF_FFF0; in2[1] = 32'h20;
        cycle();
        chk("wrap_grant", W'(obs_grant), 32'b010);
        req_valid = '0;
        chk("wrap_out", rsp_out, 32'h0000_0010);
        chk("wrap_id", W'(rsp_id), 1);

        // increment carry discarded
        req_valid = 3'b100; req_sel = 3'b100; in1[2] = 32'hFFFF_FFFC;
        cycle();
        req_valid = '0;
        chk("carry_out", rsp_out, 32'h0);

        // round robin from a fresh pointer
        rst = 1;
        cycle();
        rst = 0;
        req_valid = 3'b111; req_sel = 3'b101; rsp_ready = 1;
        in1[0] = 32'h10; in1[1] = 32'h200; in2[1] = 32'h3; in1[2] = 32'h7;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("rr_grant", W'(obs_grant), W'(rr_exp[c]));
            chk("rr_id", W'(rsp_id), W'(rr_id[c]));
        end

        // backpressure: slot full, consumer stalled
        req_valid = 3'b010; rsp_ready = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("bp_grant", W'(obs_grant), 0);
            chk("bp_out", rsp_out, 32'h14);
            chk("bp_id", W'(rsp_id), 0);
        end
        rsp_ready = 1;
        cycle();
        chk("bp_release_grant", W'(obs_grant), 32'b010);
        req_valid = '0;
        chk("bp_release_id", W'(rsp_id), 1);
        chk("bp_release_out", rsp_out, 32'h203);

        // pass-through: owner 2 drained while requester 0 accepted
        req_valid = 3'b100;
        cycle();
        chk("pt_id2", W'(rsp_id), 2);
        req_valid = 3'b001;
        cycle();
        req_valid = '0; rsp_ready = 0;
        chk("pt_valid", W'(rsp_valid), 1);
        chk("pt_id0", W'(rsp_id), 0);

        // reset mid-operation
        req_valid = 3'b111; rst = 1;
        cycle();
        chk("rst_grant", W'(obs_grant), 0);
        chk("rst_valid", W'(rsp_valid), 0);
        chk("rst_out", rsp_out, 0);
        rst = 0; req_valid = 3'b110;
        cycle();
        chk("rst_after_grant", W'(obs_grant), 32'b010);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            req_valid = N'($urandom);
            req_sel   = N'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                in1[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
                in2[i] = $urandom;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
